// File: rtl/id_hazard_scoreboard_if.sv
// ID-stage hazard interface: instruction fields in from the IF/ID register, stall/bubble controls out.
// HAZARD_FWD_EN adds the registered forwarding selects fwd_a/fwd_b.
interface id_hazard_scoreboard_if #(
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [5:0]       id_opcode;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_rd;
  logic             flush;
  logic             stall;
  logic             pc_write;
  logic             ifid_write;
  logic             id_bubble;
  logic [CNT_W-1:0] stall_count;
`ifdef HAZARD_FWD_EN
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, id_rd, flush,
    input  stall, pc_write, ifid_write, id_bubble, stall_count, fwd_a, fwd_b
  );
  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, id_rd, flush,
    output stall, pc_write, ifid_write, id_bubble, stall_count, fwd_a, fwd_b
  );
`else
  modport master (
    output id_valid, id_opcode, id_rs, id_rt, id_rd, flush,
    input  stall, pc_write, ifid_write, id_bubble, stall_count
  );
  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, id_rd, flush,
    output stall, pc_write, ifid_write, id_bubble, stall_count
  );
`endif
endinterface

// File: rtl/id_hazard_scoreboard.sv
// ID-stage hazard scheduler: 3-slot (EX/MEM/WB) destination scoreboard, stall/flush control and a
// saturating stall-cycle counter. Optional macro HAZARD_FWD_EN: load-use-only stalls plus fwd selects.
module id_hazard_scoreboard #(
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned REGFILE_BYPASS = 0
) (
  input logic                   clk,
  input logic                   rst,
  id_hazard_scoreboard_if.slave hz
);

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       load;
  } slot_t;

  slot_t            ex_q, mem_q, wb_q, push_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             use_rs, use_rt, dec_load;
  logic [4:0]       dec_dest;
  logic             hazard, stall, issue;

  function automatic logic hit(slot_t s, logic [4:0] src, logic used);
    return used && (src != 5'd0) && s.valid && (s.dest == src);
  endfunction

  always_comb begin
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    dec_dest = 5'd0;
    dec_load = 1'b0;
    case (hz.id_opcode)
      6'b000000: begin use_rs = 1'b1; use_rt = 1'b1; dec_dest = hz.id_rd; end
      6'b100011: begin use_rs = 1'b1; dec_dest = hz.id_rt; dec_load = 1'b1; end
      6'b101011: begin use_rs = 1'b1; use_rt = 1'b1; end
      6'b000100: begin use_rs = 1'b1; use_rt = 1'b1; end
      6'b001000: begin use_rs = 1'b1; dec_dest = hz.id_rt; end
      default: ;
    endcase
  end

  logic ex_rs, ex_rt, mem_rs, mem_rt, wb_rs, wb_rt;
  assign ex_rs  = hit(ex_q,  hz.id_rs, use_rs);
  assign ex_rt  = hit(ex_q,  hz.id_rt, use_rt);
  assign mem_rs = hit(mem_q, hz.id_rs, use_rs);
  assign mem_rt = hit(mem_q, hz.id_rt, use_rt);
  assign wb_rs  = hit(wb_q,  hz.id_rs, use_rs);
  assign wb_rt  = hit(wb_q,  hz.id_rt, use_rt);

`ifdef HAZARD_FWD_EN
  // With forwarding only a load still in EX cannot supply its value in time.
  assign hazard = (ex_rs | ex_rt) & ex_q.load;
`else
  assign hazard = ex_rs | ex_rt | mem_rs | mem_rt |
                  ((wb_rs | wb_rt) & (REGFILE_BYPASS == 0));
`endif

  assign stall = hz.id_valid & ~hz.flush & hazard;
  assign issue = hz.id_valid & ~stall & ~hz.flush;

  always_comb begin
    push_d = '0;
    if (issue && (dec_dest != 5'd0)) begin
      push_d = '{valid: 1'b1, dest: dec_dest, load: dec_load};
    end
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= push_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef HAZARD_FWD_EN
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  always_comb begin
    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
    if (issue) begin
      fwd_a_d = ex_rs ? 2'b10 : (mem_rs ? 2'b01 : 2'b00);
      fwd_b_d = ex_rt ? 2'b10 : (mem_rt ? 2'b01 : 2'b00);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign hz.fwd_a = fwd_a_q;
  assign hz.fwd_b = fwd_b_q;
`endif

  assign hz.stall       = stall;
  assign hz.pc_write    = ~stall;
  assign hz.ifid_write  = ~stall;
  assign hz.id_bubble   = stall | hz.flush | ~hz.id_valid;
  assign hz.stall_count = cnt_q;

endmodule
